// File: rtl/lcd_hex_fmt.sv
// lcd_hex_fmt: turns one selected channel of a multi-channel register bus into
// two 16-character ASCII lines and hands them to the LCD bus engine through a
// start/done handshake, with timeout detection.
// Optional build macro LCD_HEX_FMT_AUTO_REFRESH_EN adds a periodic self-start
// that scans the channels in turn.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a start request
// LATCH | capture channel data and index, show index on line 1
// CONV  | write one hex digit per cycle to line 2, MSB first
// KICK  | one-cycle start pulse to the LCD bus engine
// WAIT  | wait for engine completion or timeout
// FIN   | one-cycle done pulse (error pulse if timed out)
module lcd_hex_fmt #(
    parameter int DATA_W      = 32,
    parameter int NCH         = 2,
    parameter int COL         = 0,
    parameter int TIMEOUT     = 65535,
    parameter int REFRESH_CYC = 50000000,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  I_CLK,
    input  logic                  I_RSTF,
    input  logic                  I_START,
    input  logic [CH_W-1:0]       I_CH_SEL,
    input  logic [NCH*DATA_W-1:0] I_REG_DATA,
    output logic                  O_LCD_START,
    input  logic                  I_LCD_DONE,
    output logic [127:0]          O_LINE1,
    output logic [127:0]          O_LINE2,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic                  O_ERR
);

    localparam int ND    = DATA_W / 4;
    localparam int DIG_W = (ND > 1) ? $clog2(ND) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(ND - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [31:0]      NCH_U    = NCH;
    localparam logic [127:0]     LINE1_RST = "Register Ch 0   ";
    localparam logic [127:0]     LINE2_RST = {16{8'h20}};

    // Elaboration-time parameter sanity checks.
    if ((DATA_W % 4) != 0 || DATA_W < 4 || DATA_W > 64) begin : g_bad_data_w
        $error("lcd_hex_fmt: DATA_W must be a multiple of 4 in 4..64");
    end
    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("lcd_hex_fmt: NCH must be in 1..16");
    end
    if (COL < 0 || COL + DATA_W / 4 > 16) begin : g_bad_col
        $error("lcd_hex_fmt: hex digits do not fit on line 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("lcd_hex_fmt: TIMEOUT must be >= 1");
    end
    if (REFRESH_CYC < 1) begin : g_bad_refresh
        $error("lcd_hex_fmt: REFRESH_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_CONV  = 3'd2,
        S_KICK  = 3'd3,
        S_WAIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shadow;
    logic [CH_W-1:0]     chan_q;
    logic [DIG_W-1:0]    dig_q;
    logic [TO_W-1:0]     to_cnt;

    logic [CH_W-1:0]     sel_ok;
    logic [CH_W-1:0]     next_ch;
    logic [CH_W-1:0]     lat_ch;
    logic [3:0]          nib;
    logic                start_req;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Channel bookkeeping: clamp the external select, compute the scan successor.
    always_comb begin
        sel_ok  = (32'(I_CH_SEL) < NCH_U) ? I_CH_SEL : '0;
        next_ch = (32'(chan_q) >= NCH_U - 32'd1) ? '0 : chan_q + 1'b1;
        nib     = shadow[4*(ND-1-int'(dig_q)) +: 4];
    end

`ifdef LCD_HEX_FMT_AUTO_REFRESH_EN
    localparam logic [31:0] REF_LAST = 32'(REFRESH_CYC - 1);

    logic [31:0] ref_cnt;
    logic        auto_q;
    logic        ref_hit;

    // Self-start request; an external start in the same cycle takes precedence.
    always_comb begin
        ref_hit   = (state == S_IDLE) && (ref_cnt == REF_LAST);
        start_req = I_START | ref_hit;
        lat_ch    = auto_q ? next_ch : sel_ok;
    end

    // Refresh period counter: runs only while idle, holds otherwise.
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            ref_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (I_START || ref_cnt == REF_LAST)
                ref_cnt <= '0;
            else
                ref_cnt <= ref_cnt + 32'd1;
        end
    end

    // Remembers whether the pending operation was self-started.
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF)
            auto_q <= 1'b0;
        else if (state == S_IDLE && start_req)
            auto_q <= !I_START;
    end
`else
    // Operations start only from the external request.
    always_comb begin
        start_req = I_START;
        lat_ch    = sel_ok;
    end
`endif

    // Main sequencer with registered outputs.
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            state       <= S_IDLE;
            shadow      <= '0;
            chan_q      <= '0;
            dig_q       <= '0;
            to_cnt      <= '0;
            O_LINE1     <= LINE1_RST;
            O_LINE2     <= LINE2_RST;
            O_LCD_START <= 1'b0;
            O_BUSY      <= 1'b0;
            O_DONE      <= 1'b0;
            O_ERR       <= 1'b0;
        end else begin
            O_LCD_START <= 1'b0;
            O_DONE      <= 1'b0;
            O_ERR       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state  <= S_LATCH;
                        O_BUSY <= 1'b1;
                    end
                end
                S_LATCH: begin
                    shadow          <= I_REG_DATA[int'(lat_ch)*DATA_W +: DATA_W];
                    chan_q          <= lat_ch;
                    O_LINE1[31:24]  <= hex_ascii(4'(lat_ch));
                    dig_q           <= '0;
                    state           <= S_CONV;
                end
                S_CONV: begin
                    O_LINE2[8*(15-COL-int'(dig_q)) +: 8] <= hex_ascii(nib);
                    dig_q <= dig_q + 1'b1;
                    if (dig_q == DIG_LAST) begin
                        state       <= S_KICK;
                        O_LCD_START <= 1'b1;
                    end
                end
                S_KICK: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (I_LCD_DONE) begin
                        state  <= S_FIN;
                        O_DONE <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        // O_ERR doubles as the timeout flag; it self-clears after FIN.
                        state  <= S_FIN;
                        O_DONE <= 1'b1;
                        O_ERR  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    state  <= S_IDLE;
                    O_BUSY <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    O_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hex_fmt.sv
// Self-checking bench for lcd_hex_fmt: two instances with different widths,
// column offsets and channel counts, plus a third for the auto-refresh build.
module tb_lcd_hex_fmt;

    localparam int TOUT = 20;
    localparam logic [127:0] L1_RST = "Register Ch 0   ";
    localparam logic [127:0] SPACES = {16{8'h20}};

    logic        clk = 1'b0;
    logic        rstf = 1'b0;
    logic        start = 1'b0;
    logic        done_in = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] chd [3];
    int          which = 0;
    int          errors = 0;
    int          checks = 0;

    logic         a_ls, a_busy, a_done, a_err;
    logic [127:0] a_l1, a_l2;
    logic         b_ls, b_busy, b_done, b_err;
    logic [127:0] b_l1, b_l2;

    always #5 clk = ~clk;

    lcd_hex_fmt #(.DATA_W(32), .NCH(2), .COL(0), .TIMEOUT(TOUT)) dut_a (
        .I_CLK(clk), .I_RSTF(rstf),
        .I_START(start && which == 0), .I_CH_SEL(sel[0]),
        .I_REG_DATA({chd[1], chd[0]}),
        .O_LCD_START(a_ls), .I_LCD_DONE(done_in && which == 0),
        .O_LINE1(a_l1), .O_LINE2(a_l2),
        .O_BUSY(a_busy), .O_DONE(a_done), .O_ERR(a_err)
    );

    lcd_hex_fmt #(.DATA_W(16), .NCH(3), .COL(6), .TIMEOUT(TOUT)) dut_b (
        .I_CLK(clk), .I_RSTF(rstf),
        .I_START(start && which == 1), .I_CH_SEL(sel),
        .I_REG_DATA({chd[2][15:0], chd[1][15:0], chd[0][15:0]}),
        .O_LCD_START(b_ls), .I_LCD_DONE(done_in && which == 1),
        .O_LINE1(b_l1), .O_LINE2(b_l2),
        .O_BUSY(b_busy), .O_DONE(b_done), .O_ERR(b_err)
    );

`ifdef LCD_HEX_FMT_AUTO_REFRESH_EN
    logic         c_ls, c_busy, c_done, c_err;
    logic [127:0] c_l1, c_l2;
    lcd_hex_fmt #(.DATA_W(8), .NCH(3), .COL(0), .TIMEOUT(4), .REFRESH_CYC(100)) dut_c (
        .I_CLK(clk), .I_RSTF(rstf),
        .I_START(1'b0), .I_CH_SEL(2'd0),
        .I_REG_DATA({chd[2][7:0], chd[1][7:0], chd[0][7:0]}),
        .O_LCD_START(c_ls), .I_LCD_DONE(1'b0),
        .O_LINE1(c_l1), .O_LINE2(c_l2),
        .O_BUSY(c_busy), .O_DONE(c_done), .O_ERR(c_err)
    );
`endif

    function automatic logic [7:0] hexc(input int d);
        return (d < 10) ? 8'(32'h30 + d) : 8'(32'h41 + d - 10);
    endfunction

    // Expected line 1: fixed text with the channel digit at char 12.
    function automatic logic [127:0] exp_l1(input int ch);
        logic [127:0] r;
        r = L1_RST;
        r[31:24] = hexc(ch);
        return r;
    endfunction

    // Expected line 2: spaces everywhere except nd hex digits from column col.
    function automatic logic [127:0] exp_l2(input logic [31:0] v, input int nd, input int col);
        logic [127:0] r;
        for (int c = 0; c < 16; c++) begin
            if (c >= col && c < col + nd)
                r[127-8*c -: 8] = hexc(int'((v >> (4 * (nd - 1 - (c - col)))) & 32'hF));
            else
                r[127-8*c -: 8] = 8'h20;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation on instance w; dly = cycles after KICK when done is given (<0: never).
    task automatic run_op(input int w, input int s, input int dly, input bit disturb,
                          input bit early_done);
        int nd, col, nch, ch, k, d;
        bit tmo;
        logic [31:0] dv;
        logic [127:0] e1, e2;
        nd  = (w == 1) ? 4 : 8;
        col = (w == 1) ? 6 : 0;
        nch = (w == 1) ? 3 : 2;
        ch  = (s < nch) ? s : 0;
        dv  = (w == 1) ? (chd[ch] & 32'hFFFF) : chd[ch];
        e1  = exp_l1(ch);
        e2  = exp_l2(dv, nd, col);
        k   = nd + 2;
        tmo = (dly < 1) || (dly > TOUT);
        d   = tmo ? k + TOUT + 1 : k + dly + 1;
        @(negedge clk);
        which = w;
        sel   = 2'(s);
        start = 1'b1;
        for (int c = 1; c <= d + 2; c++) begin
            @(negedge clk);
            start   = 1'b0;
            done_in = 1'b0;
            chk("lcd_start", (w == 1) ? b_ls : a_ls, c == k);
            chk("busy",      (w == 1) ? b_busy : a_busy, c <= d);
            chk("done",      (w == 1) ? b_done : a_done, c == d);
            chk("err",       (w == 1) ? b_err : a_err, (c == d) && tmo);
            if (c == k || c == d) begin
                chk("line1", (w == 1) ? b_l1 : a_l1, e1);
                chk("line2", (w == 1) ? b_l2 : a_l2, e2);
            end
            if (early_done && c == 3) done_in = 1'b1;
            if (!tmo && c == k + dly) done_in = 1'b1;
            if (disturb && c == k + 2) begin
                start = 1'b1;
                for (int i = 0; i < 3; i++) chd[i] = ~chd[i];
            end
        end
        start   = 1'b0;
        done_in = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) chd[i] = 32'h0;

        // Reset values on both instances.
        #12;
        chk("rst_a_line1", a_l1, L1_RST);
        chk("rst_a_line2", a_l2, SPACES);
        chk("rst_a_outs", {a_ls, a_busy, a_done, a_err}, 4'b0);
        chk("rst_b_line1", b_l1, L1_RST);
        chk("rst_b_line2", b_l2, SPACES);
        chk("rst_b_outs", {b_ls, b_busy, b_done, b_err}, 4'b0);
        @(negedge clk);
        rstf = 1'b1;

        // Basic operation: ch1 = DEADBEEF, done five cycles after the kick.
        chd[1] = 32'hDEADBEEF;
        run_op(0, 1, 5, 1'b0, 1'b0);
        chk("basic_line2", a_l2, "DEADBEEF        ");

        // Column offset and narrower width.
        chd[0] = 32'h0000_0A3F;
        run_op(1, 0, 3, 1'b0, 1'b0);
        chk("col_line2", b_l2, "      0A3F      ");

        // Timeout with start and data disturbance during WAIT, then normal recovery.
        chd[0] = $urandom; chd[1] = $urandom;
        run_op(0, 0, -1, 1'b1, 1'b0);
        chd[0] = $urandom; chd[1] = $urandom;
        run_op(0, 1, 2, 1'b0, 1'b0);

        // Done coinciding with timeout expiry is a success.
        chd[1] = $urandom;
        run_op(0, 1, TOUT, 1'b0, 1'b0);

        // Done during CONV is ignored; first-cycle-of-WAIT done.
        chd[0] = $urandom;
        run_op(0, 0, 1, 1'b0, 1'b1);

        // Out-of-range channel select falls back to channel 0.
        for (int i = 0; i < 3; i++) chd[i] = $urandom;
        run_op(1, 3, 2, 1'b0, 1'b0);

        // Randomised operations across both instances.
        for (int n = 0; n < 8; n++) begin
            int w, s, dl;
            for (int i = 0; i < 3; i++) chd[i] = $urandom;
            w  = int'($urandom_range(1, 0));
            s  = (w == 1) ? int'($urandom_range(3, 0)) : int'($urandom_range(1, 0));
            dl = int'($urandom_range(TOUT + 3, 1));
            run_op(w, s, dl, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // Reset in the middle of CONV: immediate reset values, no done pulse.
        chd[1] = 32'h12345678;
        @(negedge clk);
        which = 0; sel = 2'd1; start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        rstf = 1'b0;
        #1;
        chk("midrst_line1", a_l1, L1_RST);
        chk("midrst_line2", a_l2, SPACES);
        chk("midrst_outs", {a_ls, a_busy, a_done, a_err}, 4'b0);
        @(negedge clk);
        rstf = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("midrst_no_done", a_done, 1'b0);
        end
        chd[0] = $urandom;
        run_op(0, 0, 4, 1'b0, 1'b0);

`ifdef LCD_HEX_FMT_AUTO_REFRESH_EN
        // Auto refresh scans channels 1, 2, 0, ... starting from reset.
        begin
            int exp_ch;
            bit got;
            chd[0] = 32'h17; chd[1] = 32'hC3; chd[2] = 32'h5A;
            @(negedge clk);
            rstf = 1'b0;
            @(negedge clk);
            rstf = 1'b1;
            exp_ch = 0;
            for (int n = 0; n < 6; n++) begin
                exp_ch = (exp_ch + 1) % 3;
                got = 1'b0;
                for (int t = 0; t < 400 && !got; t++) begin
                    @(negedge clk);
                    if (c_done === 1'b1) got = 1'b1;
                end
                chk("refresh_seen", got, 1'b1);
                chk("refresh_ch", c_l1, exp_l1(exp_ch));
                chk("refresh_line2", c_l2, exp_l2(chd[exp_ch] & 32'hFF, 2, 0));
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
